// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with registered reads,
// same-cycle write-to-read bypass and a per-register busy scoreboard.
// Register 0 is hardwired to zero and can never be marked busy.
//
// Ports (port p occupies slice [p*W +: W] of each packed per-port field):
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-low reset
//   rd_addr    in   NRD*AW   read address per port
//   rd_data    out  NRD*XLEN registered read data per port
//   rd_busy    out  NRD      registered busy flag per port
//   wr_en      in   write strobe
//   wr_addr    in   AW       write address
//   wr_data    in   XLEN     write data
//   busy_set   in   mark busy_addr busy (producer issued)
//   busy_addr  in   AW       register to mark busy
//   busy_vec   out  NREG     current scoreboard, direct register output
module regfile_mp #(
  parameter  int XLEN      = 32,
  parameter  int NREG      = 32,
  parameter  int NRD       = 2,
  parameter  int INIT_MODE = 0,
  localparam int AW        = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                busy_set,
  input  logic [AW-1:0]       busy_addr,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0]     mem [NREG];
  logic [NREG-1:0]     busy_nxt;
  logic [NRD*XLEN-1:0] rd_data_nxt;
  logic [NRD-1:0]      rd_busy_nxt;
  logic [AW-1:0]       ra;

  // Storage array; entry 0 is never written so it always holds zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (INIT_MODE == 1 && i != 0) mem[i] <= XLEN'(i * 10);
        else                          mem[i] <= '0;
      end
    end else if (wr_en && wr_addr != '0) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Scoreboard next state: retire clears, issue sets afterwards so that an
  // issue-after-retire to the same register leaves it busy.
  always_comb begin
    busy_nxt = busy_vec;
    if (wr_en)    busy_nxt[wr_addr]   = 1'b0;
    if (busy_set) busy_nxt[busy_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_vec <= '0;
    else      busy_vec <= busy_nxt;
  end

  // Read ports see the post-edge view: write data is forwarded and the busy
  // flag is taken from the resolved next scoreboard.
  always_comb begin
    rd_data_nxt = '0;
    rd_busy_nxt = '0;
    ra          = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      ra = rd_addr[p*AW +: AW];
      if (ra == '0)
        rd_data_nxt[p*XLEN +: XLEN] = '0;
      else if (wr_en && wr_addr == ra)
        rd_data_nxt[p*XLEN +: XLEN] = wr_data;
      else
        rd_data_nxt[p*XLEN +: XLEN] = mem[ra];
      rd_busy_nxt[p] = busy_nxt[ra];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      rd_data <= rd_data_nxt;
      rd_busy <= rd_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: XLEN=32, NREG=32, NRD=2, INIT_MODE=1
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_busy_set;
  logic [4:0]  a_busy_addr;
  logic [31:0] a_busy_vec;

  // Instance B: XLEN=64, NREG=16, NRD=3, INIT_MODE=0
  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_busy_set;
  logic [3:0]   b_busy_addr;
  logic [15:0]  b_busy_vec;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .INIT_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .busy_set(a_busy_set), .busy_addr(a_busy_addr),
    .busy_vec(a_busy_vec));

  regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .INIT_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .busy_set(b_busy_set), .busy_addr(b_busy_addr),
    .busy_vec(b_busy_vec));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: architectural register contents and busy bits.
  logic [31:0] ma  [32];
  bit          mab [32];
  logic [63:0] mb  [16];
  bit          mbb [16];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      ma[i]  = 32'(i * 10);
      mab[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      mb[i]  = '0;
      mbb[i] = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a_rd_data"}, a_rd_data, 64'd0);
    check({tag, " a_rd_busy"}, {62'd0, a_rd_busy}, 64'd0);
    check({tag, " a_busy_vec"}, {32'd0, a_busy_vec}, 64'd0);
    for (int p = 0; p < 3; p++)
      check($sformatf("%s b_rd_data[%0d]", tag, p), b_rd_data[p*64 +: 64], 64'd0);
    check({tag, " b_rd_busy"}, {61'd0, b_rd_busy}, 64'd0);
    check({tag, " b_busy_vec"}, {48'd0, b_busy_vec}, 64'd0);
  endtask

  // One clock edge: advance the model with the inputs currently driven,
  // then compare every output of both instances.
  task automatic cycle();
    int addr;
    logic [31:0] ev_a;
    logic [15:0] ev_b;
    @(posedge clk);
    #1;
    if (a_wr_en && a_wr_addr != 0) begin
      ma[a_wr_addr]  = a_wr_data;
      mab[a_wr_addr] = 1'b0;
    end
    if (a_busy_set && a_busy_addr != 0) mab[a_busy_addr] = 1'b1;
    if (b_wr_en && b_wr_addr != 0) begin
      mb[b_wr_addr]  = b_wr_data;
      mbb[b_wr_addr] = 1'b0;
    end
    if (b_busy_set && b_busy_addr != 0) mbb[b_busy_addr] = 1'b1;

    for (int p = 0; p < 2; p++) begin
      addr = int'(a_rd_addr[p*5 +: 5]);
      check($sformatf("a_rd_data[%0d] x%0d", p, addr), {32'd0, a_rd_data[p*32 +: 32]},
            (addr == 0) ? 64'd0 : {32'd0, ma[addr]});
      check($sformatf("a_rd_busy[%0d] x%0d", p, addr), {63'd0, a_rd_busy[p]},
            {63'd0, mab[addr]});
    end
    for (int p = 0; p < 3; p++) begin
      addr = int'(b_rd_addr[p*4 +: 4]);
      check($sformatf("b_rd_data[%0d] x%0d", p, addr), b_rd_data[p*64 +: 64],
            (addr == 0) ? 64'd0 : mb[addr]);
      check($sformatf("b_rd_busy[%0d] x%0d", p, addr), {63'd0, b_rd_busy[p]},
            {63'd0, mbb[addr]});
    end
    for (int i = 0; i < 32; i++) ev_a[i] = mab[i];
    for (int i = 0; i < 16; i++) ev_b[i] = mbb[i];
    check("a_busy_vec", {32'd0, a_busy_vec}, {32'd0, ev_a});
    check("b_busy_vec", {48'd0, b_busy_vec}, {48'd0, ev_b});
  endtask

  task automatic rand_a();
    a_wr_en     = 1'($urandom_range(0, 1));
    a_wr_addr   = 5'($urandom_range(0, 31));
    a_wr_data   = $urandom;
    a_busy_set  = 1'($urandom_range(0, 1));
    a_busy_addr = ($urandom_range(0, 2) == 0) ? a_wr_addr : 5'($urandom_range(0, 31));
    for (int p = 0; p < 2; p++)
      a_rd_addr[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? a_wr_addr : 5'($urandom_range(0, 31));
  endtask

  task automatic rand_b();
    logic [3:0] base;
    int mode;
    b_wr_en     = 1'($urandom_range(0, 1));
    b_wr_addr   = 4'($urandom_range(0, 15));
    b_wr_data   = {$urandom, $urandom};
    b_busy_set  = 1'($urandom_range(0, 1));
    b_busy_addr = ($urandom_range(0, 2) == 0) ? b_wr_addr : 4'($urandom_range(0, 15));
    mode = int'($urandom_range(0, 2));
    base = ($urandom_range(0, 1) == 0) ? b_wr_addr : 4'($urandom_range(0, 15));
    for (int p = 0; p < 3; p++) begin
      case (mode)
        0:       b_rd_addr[p*4 +: 4] = base;                     // identical
        1:       b_rd_addr[p*4 +: 4] = base ^ 4'(p);             // distinct
        default: b_rd_addr[p*4 +: 4] = 4'($urandom_range(0, 15));
      endcase
    end
  endtask

  task automatic drive_a(input bit we, input int wa, input logic [31:0] wd,
                         input bit bs, input int ba, input int r1, input int r0);
    a_wr_en     = we;
    a_wr_addr   = 5'(wa);
    a_wr_data   = wd;
    a_busy_set  = bs;
    a_busy_addr = 5'(ba);
    a_rd_addr   = {5'(r1), 5'(r0)};
  endtask

  initial begin
    rst = 1'b1;
    drive_a(0, 0, '0, 0, 0, 0, 0);
    b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0;
    b_busy_set = 0; b_busy_addr = '0; b_rd_addr = '0;
    model_reset();
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    #10 rst = 1'b1;

    // Test-pattern contents: port 1 reads x5, port 0 reads x31
    drive_a(0, 0, '0, 0, 0, 5, 31); rand_b();
    cycle();
    check("init x5", {32'd0, a_rd_data[63:32]}, 64'd50);
    check("init x31", {32'd0, a_rd_data[31:0]}, 64'd310);

    drive_a(0, 0, '0, 0, 0, 0, 0); rand_b();
    cycle();
    check("x0 read", a_rd_data, 64'd0);

    // Write x7 with port 0 reading it in the same cycle
    drive_a(1, 7, 32'hDEADBEEF, 0, 0, 5, 7); rand_b();
    cycle();
    check("bypass x7", {32'd0, a_rd_data[31:0]}, 64'h0DEADBEEF);
    drive_a(0, 0, '0, 0, 0, 7, 0); rand_b();
    cycle();
    check("x7 port1", {32'd0, a_rd_data[63:32]}, 64'h0DEADBEEF);

    // x0 protection
    drive_a(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0); rand_b();
    cycle();
    drive_a(0, 0, '0, 0, 0, 0, 0); rand_b();
    cycle();
    check("x0 after write", a_rd_data, 64'd0);
    check("busy_vec[0]", {63'd0, a_busy_vec[0]}, 64'd0);

    // Scoreboard ordering on x3
    drive_a(0, 0, '0, 1, 3, 0, 3); rand_b();
    cycle();
    check("busy x3 set", {63'd0, a_busy_vec[3]}, 64'd1);
    drive_a(0, 0, '0, 0, 0, 0, 3); rand_b();
    cycle();
    drive_a(1, 3, 32'h0000_1111, 0, 0, 0, 3); rand_b();
    cycle();
    check("busy x3 cleared", {63'd0, a_busy_vec[3]}, 64'd0);
    drive_a(1, 3, 32'h1234_5678, 1, 3, 0, 3); rand_b();
    cycle();
    check("set wins x3", {63'd0, a_busy_vec[3]}, 64'd1);
    check("data x3", {32'd0, a_rd_data[31:0]}, 64'h1234_5678);
    check("rd_busy x3", {63'd0, a_rd_busy[0]}, 64'd1);

    for (int n = 0; n < 2000; n++) begin
      rand_a(); rand_b();
      cycle();
    end

    // Asynchronous reset between edges with traffic in flight
    rand_a(); rand_b();
    #2 rst = 1'b0;
    #1 check_all_zero("async reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_a(0, 0, '0, 0, 0, 0, 7); rand_b();
    cycle();
    check("x7 after reset", {32'd0, a_rd_data[31:0]}, 64'd70);

    for (int n = 0; n < 10000; n++) begin
      rand_a(); rand_b();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file with registered reads, write-to-read bypass and a per-register busy scoreboard. It is the next generation of the core's register file and serves the pipelined datapath. Decode reads operands and marks destination registers busy. Writeback retires results and clears busy. Register 0 is hardwired to zero.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports (≥ 1)
- INIT_MODE, 0, reset contents: 0 = all zero; 1 = test pattern, register i = i*10 (register 0 still reads 0)
- AW, $clog2(NREG), address width (derived, not overridden)

Ports (all port p fields are packed; port p occupies slice [p*W +: W]):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous and active-low; asserting low clears state immediately
- rd_addr  in  NRD*AW  read address, one per port
- rd_data  out  NRD*XLEN  registered read data
- rd_busy  out  NRD  registered busy flag for each read address
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- busy_set  in  1  marks busy_addr busy (producer issued)
- busy_addr  in  AW  register to mark busy
- busy_vec  out  NREG  current scoreboard (bit 0 always 0)

## Operation
- Storage: NREG x XLEN array plus an NREG-bit busy vector.
- Reset (rst low, asynchronous):
  - array loaded per INIT_MODE
  - busy_vec = 0
  - rd_data = 0, rd_busy = 0
- Write: on a clk edge with wr_en=1 and wr_addr≠0, reg[wr_addr] ← wr_data and busy[wr_addr] ← 0.
- Writes to address 0 are discarded; busy[0] is never set.
- Busy set: on a clk edge with busy_set=1 and busy_addr≠0, busy[busy_addr] ← 1.
- Simultaneous set and clear on the same address: set wins. This is an issue-after-retire to the same destination, and the register must end busy.
- Read, every cycle, every port p: on the clk edge, rd_data[p] ← value of reg[rd_addr[p]] after this edge's write.
  - Write bypass: if wr_en=1 and wr_addr=rd_addr[p]≠0, rd_data[p] ← wr_data, not the stale array value.
  - rd_addr[p]=0 → rd_data[p] ← 0 regardless of write activity.
- rd_busy[p] ← busy[rd_addr[p]] after this edge's set/clear resolution, with the same priority as the busy vector. Address 0 always gives 0.
- All read ports are independent. Any number of ports may read the same address, and all of them get identical results.
- No write port conflicts exist (single write port). There is no back-pressure or handshake: the block accepts one write and one busy-set every cycle.

## Timing
- Read latency: 1 cycle. Address presented before edge N; data and busy flag valid after edge N until edge N+1.
- Write-to-read: a write at edge N is visible on rd_data at edge N (bypass), i.e. same-cycle forwarding.
- Busy set at edge N: the flag appears in busy_vec immediately after edge N and in rd_busy on reads sampled at edge N.
- Busy clear by write at edge N: the same timing as busy set.
- busy_vec is a direct register output, with no combinational path from any input.
- Reset mid-operation: any in-flight write at the asserting edge is lost. The outputs take reset values asynchronously, without waiting for clk. First valid read occurs on the first clk edge after rst returns high.
- wr_addr, busy_addr and rd_addr are always in range (NREG is a power of two), so there is no out-of-range behaviour.

## Test plan
- Reset with INIT_MODE=1, NRD=2:
  - rd_addr = {5, 31} → after one edge rd_data = {50, 310}, rd_busy = {0, 0}
  - rd_addr = 0 → 0
- Write then read: wr x7 ← 0xDEADBEEF at edge N, with port 0 reading x7 in the same cycle → port 0 = 0xDEADBEEF after edge N (bypass). Port 1 reading x7 at edge N+1 → 0xDEADBEEF.
- x0 protection: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF and busy_set on address 0 → reads of x0 return 0; busy_vec[0] = 0.
- Scoreboard ordering:
  - busy_set x3 at edge N → busy_vec[3]=1
  - write x3 at edge N+2 → busy_vec[3]=0
  - set and write x3 at the same edge → busy_vec[3]=1 and the data updated
- Async reset mid-stream: drive random writes/sets, pull rst low between edges → busy_vec = 0 and rd_data = 0 immediately. After release, x7 reads 70 (INIT_MODE=1).
- Parametric sweep:
  - XLEN=64, NREG=16, NRD=3: all three ports read distinct and identical addresses against a reference model over 10k random cycles, with zero mismatches.
